// File: rtl/mips_writeback_queue_if.sv
// Handshake and register-file write-port bundle for mips_writeback_queue.
// The forwarding lookup signals exist only when WB_FORWARD_EN is defined.
interface mips_writeback_queue_if;
    logic        AluValid;
    logic [4:0]  AluAddr;
    logic [31:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [4:0]  MemAddr;
    logic [31:0] MemData;
    logic        MemReady;
    logic        ReadReq;
    logic        RegWrite;
    logic [4:0]  WriteAddress;
    logic [31:0] DataIn;
    logic [31:0] Busy;
    logic        Empty;
`ifdef WB_FORWARD_EN
    logic [4:0]  FwdAddr;
    logic        FwdHit;
    logic [31:0] FwdData;
`endif

    modport slave (
        input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ReadReq,
        output AluReady, MemReady, RegWrite, WriteAddress, DataIn, Busy, Empty
`ifdef WB_FORWARD_EN
        , input FwdAddr, output FwdHit, FwdData
`endif
    );

    modport master (
        output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData, ReadReq,
        input  AluReady, MemReady, RegWrite, WriteAddress, DataIn, Busy, Empty
`ifdef WB_FORWARD_EN
        , output FwdAddr, input FwdHit, FwdData
`endif
    );
endinterface

// File: rtl/mips_writeback_queue.sv
// In-order write-back queue feeding the MIPS register-file write port.
// Optional store-to-read forwarding lookup is enabled with WB_FORWARD_EN.
module mips_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    mips_writeback_queue_if.slave  bus
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] entry_addr_q [DEPTH];
    logic [DATA_W-1:0] entry_data_q [DEPTH];

    logic              not_full;
    logic              mem_ready;
    logic              alu_ready;
    logic              mem_acc;
    logic              alu_acc;
    logic              enq;
    logic              deq;
    logic              empty;
    logic [ADDR_W-1:0] enq_addr;
    logic [DATA_W-1:0] enq_data;
    logic [31:0]       busy;

    // Readiness is judged on the count before any same-cycle dequeue.
    always_comb begin
        not_full  = (count_q < CNT_W'(DEPTH));
        mem_ready = RESETn & not_full;
        alu_ready = mem_ready & ~bus.MemValid;
        mem_acc   = bus.MemValid & mem_ready;
        alu_acc   = bus.AluValid & alu_ready;
        enq_addr  = mem_acc ? bus.MemAddr : bus.AluAddr;
        enq_data  = mem_acc ? bus.MemData : bus.AluData;
        // Writes to r0 complete the handshake but never occupy a slot.
        enq       = (mem_acc | alu_acc) & (enq_addr != '0);
        empty     = (count_q == '0);
        deq       = RESETn & ~empty & ~bus.ReadReq;

        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (deq) head_d = head_q + PTR_W'(1);
        if (enq) tail_d = tail_q + PTR_W'(1);
        count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        if (enq) begin
            entry_addr_q[tail_q] <= enq_addr;
            entry_data_q[tail_q] <= enq_data;
        end
    end

    // Walk valid entries oldest to newest so later matches win the forward mux.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx  = '0;
        busy = '0;
`ifdef WB_FORWARD_EN
        bus.FwdHit  = 1'b0;
        bus.FwdData = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                busy[entry_addr_q[idx]] = 1'b1;
`ifdef WB_FORWARD_EN
                if ((bus.FwdAddr != '0) && (entry_addr_q[idx] == bus.FwdAddr)) begin
                    bus.FwdHit  = 1'b1;
                    bus.FwdData = entry_data_q[idx];
                end
`endif
            end
        end
        busy[0] = 1'b0;
    end

    assign bus.MemReady     = mem_ready;
    assign bus.AluReady     = alu_ready;
    assign bus.RegWrite     = deq;
    assign bus.WriteAddress = empty ? '0 : entry_addr_q[head_q];
    assign bus.DataIn       = empty ? '0 : entry_data_q[head_q];
    assign bus.Busy         = busy;
    assign bus.Empty        = empty;
endmodule

// File: tb/tb_mips_writeback_queue.sv
// Bench for mips_writeback_queue: vector table plus a queue model of expected writes.
module tb_mips_writeback_queue;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RESETn;
    always #5 CLK = ~CLK;

    mips_writeback_queue_if bus();

    mips_writeback_queue #(.DEPTH(DEPTH)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    typedef struct {
        logic        rstn;
        logic        rr;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic [4:0]  fa;
        logic        e_mrdy;
        logic        e_ardy;
        logic        e_rw;
        logic        e_empty;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t sbq[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    logic        last_fhit;
    logic [31:0] last_fdata;

    function automatic vec_t V(logic rstn, logic rr, logic mv, logic [4:0] ma, logic [31:0] md,
                               logic av, logic [4:0] aa, logic [31:0] ad,
                               logic em, logic ea, logic erw, logic eemp);
        vec_t t;
        t.rstn = rstn; t.rr = rr; t.mv = mv; t.ma = ma; t.md = md;
        t.av = av; t.aa = aa; t.ad = ad; t.fa = 5'd0;
        t.e_mrdy = em; t.e_ardy = ea; t.e_rw = erw; t.e_empty = eemp;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // mode 0: drive only; 1: compare against queue model; 2: also against table expectations
    task automatic drive_cycle(input vec_t v, input int mode);
        logic        m_rdy, a_rdy, e_rw, e_hit;
        logic [31:0] e_busy, e_wa, e_wd, e_fd;
        @(negedge CLK);
        RESETn       = v.rstn;
        bus.ReadReq  = v.rr;
        bus.MemValid = v.mv; bus.MemAddr = v.ma; bus.MemData = v.md;
        bus.AluValid = v.av; bus.AluAddr = v.aa; bus.AluData = v.ad;
`ifdef WB_FORWARD_EN
        bus.FwdAddr  = v.fa;
`endif
        #1;
        m_rdy  = v.rstn && (sbq.size() < DEPTH);
        a_rdy  = m_rdy && !v.mv;
        e_rw   = v.rstn && (sbq.size() > 0) && !v.rr;
        e_busy = '0;
        e_hit  = 1'b0;
        e_fd   = '0;
        foreach (sbq[i]) begin
            e_busy[sbq[i].a] = 1'b1;
            if (v.fa != 5'd0 && sbq[i].a == v.fa) begin
                e_hit = 1'b1;
                e_fd  = sbq[i].d;
            end
        end
        e_wa = (sbq.size() > 0) ? 32'(sbq[0].a) : 32'd0;
        e_wd = (sbq.size() > 0) ? sbq[0].d : 32'd0;
        if (mode >= 1) begin
            chk("MemReady",     32'(bus.MemReady),     32'(m_rdy));
            chk("AluReady",     32'(bus.AluReady),     32'(a_rdy));
            chk("RegWrite",     32'(bus.RegWrite),     32'(e_rw));
            chk("WriteAddress", 32'(bus.WriteAddress), e_wa);
            chk("DataIn",       bus.DataIn,            e_wd);
            chk("Busy",         bus.Busy,              e_busy);
            chk("Empty",        32'(bus.Empty),        32'(sbq.size() == 0));
`ifdef WB_FORWARD_EN
            chk("FwdHit",       32'(bus.FwdHit),       32'(e_hit));
            chk("FwdData",      bus.FwdData,           e_fd);
            last_fhit  = bus.FwdHit;
            last_fdata = bus.FwdData;
`endif
        end
        if (mode == 2) begin
            chk("tbl_MemReady", 32'(bus.MemReady), 32'(v.e_mrdy));
            chk("tbl_AluReady", 32'(bus.AluReady), 32'(v.e_ardy));
            chk("tbl_RegWrite", 32'(bus.RegWrite), 32'(v.e_rw));
            chk("tbl_Empty",    32'(bus.Empty),    32'(v.e_empty));
        end
        if (!v.rstn) begin
            sbq.delete();
        end else begin
            if (e_rw) void'(sbq.pop_front());
            if (v.mv && m_rdy) begin
                if (v.ma != 5'd0) sbq.push_back({v.ma, v.md});
            end else if (v.av && a_rdy) begin
                if (v.aa != 5'd0) sbq.push_back({v.aa, v.ad});
            end
        end
    endtask

    initial begin
        vec_t t;
        RESETn = 1'b0;
        bus.ReadReq = 1'b0;
        bus.MemValid = 1'b0; bus.MemAddr = '0; bus.MemData = '0;
        bus.AluValid = 1'b0; bus.AluAddr = '0; bus.AluData = '0;
`ifdef WB_FORWARD_EN
        bus.FwdAddr = '0;
`endif
        last_fhit = 1'b0;
        last_fdata = '0;

        drive_cycle(V(0,0,0,0,0,0,0,0, 0,0,0,1), 0);
        drive_cycle(V(0,0,0,0,0,0,0,0, 0,0,0,1), 2);
        drive_cycle(V(1,0,0,0,0,0,0,0, 1,1,0,1), 2);

        // single ALU write
        tbl.push_back(V(1,0, 0,0,0,            1,5,32'hDEADBEEF, 1,1,0,1));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,0,1));
        // load beats ALU in the same cycle
        tbl.push_back(V(1,0, 1,3,32'h33,       1,4,32'h44,       1,0,0,1));
        tbl.push_back(V(1,0, 0,0,0,            1,4,32'h44,       1,1,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,0,1));
        // fill with ReadReq held high
        tbl.push_back(V(1,1, 1,10,32'hA0,      0,0,0,            1,0,0,1));
        tbl.push_back(V(1,1, 0,0,0,            1,11,32'hA1,      1,1,0,0));
        tbl.push_back(V(1,1, 1,12,32'hA2,      0,0,0,            1,0,0,0));
        tbl.push_back(V(1,1, 0,0,0,            1,13,32'hA3,      1,1,0,0));
        tbl.push_back(V(1,1, 1,14,32'hA4,      0,0,0,            0,0,0,0));
        tbl.push_back(V(1,0, 1,14,32'hA4,      0,0,0,            0,0,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,0,1));
        // register 0 is discarded
        tbl.push_back(V(1,0, 1,0,32'h1234,     0,0,0,            1,0,0,1));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,0,1));
        // ReadReq stalls the head write by two cycles
        tbl.push_back(V(1,0, 0,0,0,            1,20,32'hC0FFEE,  1,1,0,1));
        tbl.push_back(V(1,1, 0,0,0,            0,0,0,            1,1,0,0));
        tbl.push_back(V(1,1, 0,0,0,            0,0,0,            1,1,0,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,1,0));
        tbl.push_back(V(1,0, 0,0,0,            0,0,0,            1,1,0,1));
        foreach (tbl[i]) drive_cycle(tbl[i], 2);

        // back-to-back loads: one write per cycle, pointers wrap several times
        for (int i = 0; i < 10; i++)
            drive_cycle(V(1,0, 1,5'(i + 1),$urandom, 0,0,0, 1,0,0,0), 1);
        drive_cycle(V(1,0, 0,0,0, 0,0,0, 1,1,1,0), 2);
        drive_cycle(V(1,0, 0,0,0, 0,0,0, 1,1,0,1), 2);

        // reset while draining three entries
        drive_cycle(V(1,1, 1,1,32'h101, 0,0,0, 1,0,0,1), 2);
        drive_cycle(V(1,1, 1,2,32'h102, 0,0,0, 1,0,0,0), 2);
        drive_cycle(V(1,1, 1,3,32'h103, 0,0,0, 1,0,0,0), 2);
        drive_cycle(V(1,0, 0,0,0,       0,0,0, 1,1,1,0), 2);
        drive_cycle(V(0,0, 0,0,0,       0,0,0, 0,0,0,0), 2);
        drive_cycle(V(1,0, 0,0,0,       0,0,0, 1,1,0,1), 2);
        drive_cycle(V(1,0, 0,0,0,       0,0,0, 1,1,0,1), 2);

`ifdef WB_FORWARD_EN
        drive_cycle(V(1,1, 1,7,32'h11, 0,0,0,       1,0,0,1), 2);
        drive_cycle(V(1,1, 0,0,0,       1,7,32'h22, 1,1,0,0), 2);
        t = V(1,1, 0,0,0, 0,0,0, 1,1,0,0);
        t.fa = 5'd7;
        drive_cycle(t, 2);
        chk("fwd_hit_r7",  32'(last_fhit), 32'd1);
        chk("fwd_data_r7", last_fdata,     32'h22);
        t.fa = 5'd0;
        drive_cycle(t, 2);
        chk("fwd_hit_r0",  32'(last_fhit), 32'd0);
        drive_cycle(V(1,0, 0,0,0, 0,0,0, 1,1,1,0), 2);
        drive_cycle(V(1,0, 0,0,0, 0,0,0, 1,1,1,0), 2);
        drive_cycle(V(1,0, 0,0,0, 0,0,0, 1,1,0,1), 2);
`else
        t = V(1,0, 0,0,0, 0,0,0, 1,1,0,1);
        drive_cycle(t, 2);
`endif

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_writeback_queue.md
# mips_writeback_queue

Write-side initiator for the MIPS register file. It accepts completed results from the ALU and load paths through valid/ready handshakes and buffers them in a DEPTH-entry in-order queue. It drives the register file's RegWrite/WriteAddress/DataIn write port at most once per cycle. It yields the port whenever decode needs a read cycle, and publishes a pending-write mask for hazard detection.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- CLK  in  1  single clock; all state updates on posedge.
- RESETn  in  1  reset, synchronous, active-low.
- AluValid  in  1  ALU result offered.
- AluAddr  in  5  ALU destination register.
- AluData  in  32  ALU result.
- AluReady  out  1  ALU result accepted this cycle when AluValid & AluReady.
- MemValid  in  1  load result offered.
- MemAddr  in  5  load destination register.
- MemData  in  32  load data.
- MemReady  out  1  load result accepted when MemValid & MemReady.
- ReadReq  in  1  decode needs a register-file read this cycle; write port must idle.
- RegWrite  out  1  write enable to register file.
- WriteAddress  out  5  register number to write.
- DataIn  out  32  data to write.
- Busy  out  32  bit r = 1 iff a queued entry targets register r; bit 0 always 0.
- Empty  out  1  queue holds no entries.

## Operation
- Circular buffer: head pointer, tail pointer, count (0..DEPTH). Each entry holds {addr[4:0], data[31:0]}.
- Enqueue, at most one per cycle:
  - MemReady = RESETn & (count < DEPTH).
  - AluReady = RESETn & (count < DEPTH) & !MemValid. Load has priority and the ALU is stalled that cycle.
- Accepted result with address 0:
  - Handshake completes.
  - Entry is discarded, not enqueued; count unchanged.
- Drain:
  - RegWrite = !Empty & !ReadReq.
  - WriteAddress/DataIn = head entry when !Empty; 0 when Empty.
  - Head entry is dequeued on any edge where RegWrite = 1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
  - Ready is computed from count before the dequeue. A full queue therefore refuses for that cycle even if it drains.
- Pointers wrap modulo DEPTH. count is DEPTH-width+1 bits and never exceeds DEPTH or goes below 0.
- Busy is combinational over valid entries. A register with two queued writes stays busy until both retire.
- Write order equals acceptance order. Upstream must not issue Mem and ALU results to the same register in the same cycle; that order is undefined to software.

## Timing
- Reset (RESETn low at an edge):
  - count, head and tail are cleared.
  - Next cycle: RegWrite = 0, WriteAddress = 0, DataIn = 0, Busy = 0, Empty = 1.
  - AluReady and MemReady are 0 while RESETn is low and 1 in the first cycle after release.
- Reset mid-operation: all queued entries are lost; no write is issued in the reset cycle.
- Latency: a result accepted at edge k into an empty queue appears on RegWrite in cycle k+1 and is written at edge k+1. Latency is 1 cycle minimum, with no bypass.
- ReadReq high for n cycles delays the head write by exactly n cycles. Entries continue to enqueue while space remains.
- Throughput: one write per cycle sustained with ReadReq low.

## Configuration
- Macro WB_FORWARD_EN.
- Defined: adds ports FwdAddr in 5, FwdHit out 1, FwdData out 32.
  - FwdHit = 1 iff FwdAddr != 0 and some queued entry matches FwdAddr.
  - FwdData = data of the newest (closest to tail) matching entry; 0 when no hit.
  - Purely combinational from queue state; enqueues in the current cycle are not visible.
- Undefined: these ports and the lookup logic are absent; all other behaviour is identical.

## Test plan
- Reset then single ALU write:
  - Stimulus: AluValid=1, AluAddr=5, AluData=0xDEADBEEF for one cycle.
  - Required: next cycle RegWrite=1, WriteAddress=5, DataIn=0xDEADBEEF, Busy[5]=1 in that cycle only; then Empty=1.
- Priority:
  - Stimulus: MemValid and AluValid both high, addresses 3 and 4.
  - Required: AluReady=0 that cycle. Writes occur in the order r3 then r4 once ALU re-offers.
- Fill with ReadReq held high, DEPTH=4:
  - Stimulus: offer 5 results.
  - Required: 4 accepted, 5th sees MemReady=0, RegWrite=0 throughout. On ReadReq release, 4 writes on consecutive cycles in acceptance order.
- Register 0:
  - Stimulus: accept MemAddr=0, MemData=0x1234.
  - Required: handshake completes, no RegWrite, Busy=0, Empty stays 1.
- Reset mid-drain:
  - Stimulus: 3 queued entries, RESETn low for one edge.
  - Required: following cycle RegWrite=0, Busy=0, Empty=1, no stale entry ever written.
- WB_FORWARD_EN:
  - Stimulus: queue r7=0x11 then r7=0x22 with ReadReq high, FwdAddr=7.
  - Required: FwdHit=1, FwdData=0x22. With FwdAddr=0: FwdHit=0.
